// File: rtl/kbd_display_ctrl.sv
// PS/2 scan-code consumer driving six 7-segment digits: scan code, ASCII and BCD press count.
// Optional macro EXT_CODE_EN enables tracking of E0-prefixed extended codes.
module kbd_display_ctrl #(
    parameter int COUNT_REPEAT = 0,
    parameter int COUNT_MOD    = 100
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ready,
    input  logic [7:0]  data,
    output logic        nextdata_n,
    output logic [23:0] digit,
    output logic [5:0]  digit_en
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [3:0] WRAP_TENS = 4'((COUNT_MOD - 1) / 10);
    localparam logic [3:0] WRAP_ONES = 4'((COUNT_MOD - 1) % 10);

    state_t      state_reg, state_next;
    logic        nextdata_n_reg, nextdata_n_next;
    logic [7:0]  byte_reg, byte_next;
    logic [7:0]  code_reg, code_next;
    logic        brk_reg, brk_next;
    logic        held_reg, held_next;
    logic        ext_reg, ext_next;
    logic        cur_ext_reg, cur_ext_next;
    logic [3:0]  ones_reg, ones_next;
    logic [3:0]  tens_reg, tens_next;
    logic        inc;
    logic        same_key;
    logic [7:0]  ascii_val;
    logic        mapped;
    logic        ascii_on;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg      <= IDLE;
            nextdata_n_reg <= 1'b1;
            byte_reg       <= 8'h00;
            code_reg       <= 8'h00;
            brk_reg        <= 1'b0;
            held_reg       <= 1'b0;
            ext_reg        <= 1'b0;
            cur_ext_reg    <= 1'b0;
            ones_reg       <= 4'd0;
            tens_reg       <= 4'd0;
        end else begin
            state_reg      <= state_next;
            nextdata_n_reg <= nextdata_n_next;
            byte_reg       <= byte_next;
            code_reg       <= code_next;
            brk_reg        <= brk_next;
            held_reg       <= held_next;
            ext_reg        <= ext_next;
            cur_ext_reg    <= cur_ext_next;
            ones_reg       <= ones_next;
            tens_reg       <= tens_next;
        end
    end

    // A byte only matches the held key when its extended-prefix status matches too.
    assign same_key = held_reg && (byte_reg == code_reg) && (cur_ext_reg == ext_reg);

    always_comb begin
        state_next      = state_reg;
        nextdata_n_next = 1'b1;
        byte_next       = byte_reg;
        code_next       = code_reg;
        brk_next        = brk_reg;
        held_next       = held_reg;
        ext_next        = ext_reg;
        cur_ext_next    = cur_ext_reg;
        ones_next       = ones_reg;
        tens_next       = tens_reg;
        inc             = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ready) begin
                    state_next      = ACK;
                    byte_next       = data;
                    nextdata_n_next = 1'b0;
                end
            end
            ACK: begin
                state_next = IDLE;
                if (byte_reg == 8'hF0) begin
                    brk_next = 1'b1;
                end else if (byte_reg == 8'hE0) begin
`ifdef EXT_CODE_EN
                    ext_next = 1'b1;
`endif
                end else if (brk_reg) begin
                    brk_next = 1'b0;
                    ext_next = 1'b0;
                    if (same_key) begin
                        held_next = 1'b0;
                    end
                end else if (same_key) begin
                    ext_next = 1'b0;
                    inc      = (COUNT_REPEAT != 0);
                end else begin
                    code_next    = byte_reg;
                    cur_ext_next = ext_reg;
                    held_next    = 1'b1;
                    ext_next     = 1'b0;
                    inc          = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Two-digit BCD counter wrapping to 00 after COUNT_MOD-1.
        if (inc) begin
            if (tens_reg == WRAP_TENS && ones_reg == WRAP_ONES) begin
                ones_next = 4'd0;
                tens_next = 4'd0;
            end else if (ones_reg == 4'd9) begin
                ones_next = 4'd0;
                tens_next = tens_reg + 4'd1;
            end else begin
                ones_next = ones_reg + 4'd1;
            end
        end
    end

    always_comb begin
        mapped    = 1'b1;
        ascii_val = 8'h00;
        case (code_reg)
            8'h1C: ascii_val = 8'h61;
            8'h32: ascii_val = 8'h62;
            8'h21: ascii_val = 8'h63;
            8'h23: ascii_val = 8'h64;
            8'h24: ascii_val = 8'h65;
            8'h2B: ascii_val = 8'h66;
            8'h34: ascii_val = 8'h67;
            8'h33: ascii_val = 8'h68;
            8'h43: ascii_val = 8'h69;
            8'h3B: ascii_val = 8'h6A;
            8'h42: ascii_val = 8'h6B;
            8'h4B: ascii_val = 8'h6C;
            8'h3A: ascii_val = 8'h6D;
            8'h31: ascii_val = 8'h6E;
            8'h44: ascii_val = 8'h6F;
            8'h4D: ascii_val = 8'h70;
            8'h15: ascii_val = 8'h71;
            8'h2D: ascii_val = 8'h72;
            8'h1B: ascii_val = 8'h73;
            8'h2C: ascii_val = 8'h74;
            8'h3C: ascii_val = 8'h75;
            8'h2A: ascii_val = 8'h76;
            8'h1D: ascii_val = 8'h77;
            8'h22: ascii_val = 8'h78;
            8'h35: ascii_val = 8'h79;
            8'h1A: ascii_val = 8'h7A;
            8'h45: ascii_val = 8'h30;
            8'h16: ascii_val = 8'h31;
            8'h1E: ascii_val = 8'h32;
            8'h26: ascii_val = 8'h33;
            8'h25: ascii_val = 8'h34;
            8'h2E: ascii_val = 8'h35;
            8'h36: ascii_val = 8'h36;
            8'h3D: ascii_val = 8'h37;
            8'h3E: ascii_val = 8'h38;
            8'h46: ascii_val = 8'h39;
            default: begin
                mapped    = 1'b0;
                ascii_val = 8'h00;
            end
        endcase
    end

    // Extended keys never show an ASCII value.
    assign ascii_on   = held_reg && mapped && !cur_ext_reg;
    assign nextdata_n = nextdata_n_reg;
    assign digit      = {tens_reg, ones_reg, ascii_val, code_reg};
    assign digit_en   = {2'b11, {2{ascii_on}}, {2{held_reg}}};

endmodule

// File: tb/tb_kbd_display_ctrl.sv
// Bench for kbd_display_ctrl: directed scenarios plus randomized key traffic against a byte-level model.
// Two instances run in lockstep: default build and one with repeat counting and a small wrap value.
module tb_kbd_display_ctrl;

    localparam int MOD1 = 7;

    logic        clk;
    logic        clrn;
    logic        ready;
    logic [7:0]  data;
    logic        nd0, nd1;
    logic [23:0] dig0, dig1;
    logic [5:0]  en0, en1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_cur;
    bit         m_brk;
    bit         m_held;
    int         m_cnt0;
    int         m_cnt1;

    logic [7:0] key_codes [36] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };
    logic [7:0] extra_codes [4] = '{8'h0E, 8'h0D, 8'h66, 8'h5A};

    kbd_display_ctrl u_dut (
        .clk        (clk),
        .clrn       (clrn),
        .ready      (ready),
        .data       (data),
        .nextdata_n (nd0),
        .digit      (dig0),
        .digit_en   (en0)
    );

    kbd_display_ctrl #(.COUNT_REPEAT(1), .COUNT_MOD(MOD1)) u_dut_rep (
        .clk        (clk),
        .clrn       (clrn),
        .ready      (ready),
        .data       (data),
        .nextdata_n (nd1),
        .digit      (dig1),
        .digit_en   (en1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Letters a..z then digits 0..9, in key_codes order.
    function automatic logic [7:0] ascii_of(input logic [7:0] code);
        for (int i = 0; i < 36; i++) begin
            if (key_codes[i] == code)
                return (i < 26) ? 8'(8'h61 + i) : 8'(8'h30 + i - 26);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] pick_code();
        int idx;
        idx = $urandom_range(0, 39);
        if (idx < 36) return key_codes[idx];
        return extra_codes[idx - 36];
    endfunction

    task automatic model_reset();
        m_cur  = 8'h00;
        m_brk  = 0;
        m_held = 0;
        m_cnt0 = 0;
        m_cnt1 = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            // prefix is consumed without effect in the default build
        end else if (m_brk) begin
            m_brk = 0;
            if (m_held && b == m_cur) m_held = 0;
        end else if (m_held && b == m_cur) begin
            m_cnt1 = (m_cnt1 + 1) % MOD1;
        end else begin
            m_cur  = b;
            m_held = 1;
            m_cnt0 = (m_cnt0 + 1) % 100;
            m_cnt1 = (m_cnt1 + 1) % MOD1;
        end
    endtask

    task automatic check_outputs();
        logic [7:0]  asc;
        logic [5:0]  exp_en;
        logic [23:0] exp_d0, exp_d1;
        asc    = ascii_of(m_cur);
        exp_en = {2'b11, (m_held && asc != 8'h00) ? 2'b11 : 2'b00, m_held ? 2'b11 : 2'b00};
        exp_d0 = {4'(m_cnt0 / 10), 4'(m_cnt0 % 10), asc, m_cur};
        exp_d1 = {4'(m_cnt1 / 10), 4'(m_cnt1 % 10), asc, m_cur};
        check_eq("digit", 32'(dig0), 32'(exp_d0));
        check_eq("digit_en", 32'(en0), 32'(exp_en));
        check_eq("digit_rep", 32'(dig1), 32'(exp_d1));
        check_eq("digit_en_rep", 32'(en1), 32'(exp_en));
    endtask

    task automatic do_reset();
        @(negedge clk);
        ready = 1'b0;
        clrn  = 1'b0;
        model_reset();
        #1;
        check_eq("rst_nextdata_n", 32'({nd0, nd1}), 32'(2'b11));
        check_outputs();
        check_eq("rst_digit_en", 32'(en0), 32'(6'b110000));
        @(negedge clk);
        clrn = 1'b1;
    endtask

    // One FIFO byte: ready up, pop seen for exactly one cycle, outputs updated one edge later.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ready = 1'b1;
        data  = b;
        @(posedge clk);
        #1;
        check_eq("pop_low", 32'({nd0, nd1}), 32'(2'b00));
        ready = 1'b0;
        data  = 8'($urandom);
        model_byte(b);
        @(posedge clk);
        #1;
        check_eq("pop_one_cycle", 32'({nd0, nd1}), 32'(2'b11));
        check_outputs();
        $display("byte %02h -> digit=%06h en=%06b | rep digit=%06h", b, dig0, en0, dig1);
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    initial begin
        logic [7:0] code;
        clrn  = 1'b0;
        ready = 1'b0;
        data  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        send_byte(8'h1C);
        check_eq("a_low16", 32'(dig0[15:0]), 32'(16'h611C));
        check_eq("a_en", 32'(en0), 32'(6'b111111));
        check_eq("a_cnt", 32'(dig0[23:16]), 32'(8'h01));
        send_byte(8'hF0);
        send_byte(8'h1C);
        check_eq("a_rel_en", 32'(en0), 32'(6'b110000));
        check_eq("a_rel_cnt", 32'(dig0[23:16]), 32'(8'h01));

        do_reset();
        repeat (3) send_byte(8'h1C);
        check_eq("typematic_cnt", 32'(dig0[23:16]), 32'(8'h01));
        check_eq("typematic_cnt_rep", 32'(dig1[23:16]), 32'(8'h03));
        send_byte(8'hF0);
        send_byte(8'h1C);

        do_reset();
        send_byte(8'h1C);
        send_byte(8'h32);
        check_eq("ovl_low16", 32'(dig0[15:0]), 32'(16'h6232));
        check_eq("ovl_cnt", 32'(dig0[23:16]), 32'(8'h02));
        send_byte(8'hF0);
        send_byte(8'h1C);
        check_eq("ovl_stale_brk_en", 32'(en0), 32'(6'b111111));
        send_byte(8'hF0);
        send_byte(8'h32);
        check_eq("ovl_rel_en", 32'(en0), 32'(6'b110000));

        do_reset();
        for (int i = 0; i < 99; i++) begin
            send_byte(8'h1C);
            send_byte(8'hF0);
            send_byte(8'h1C);
        end
        check_eq("cnt_99", 32'(dig0[23:16]), 32'(8'h99));
        send_byte(8'h1C);
        check_eq("cnt_wrap", 32'(dig0[23:16]), 32'(8'h00));
        send_byte(8'h0E);
        check_eq("unmapped_en", 32'(en0), 32'(6'b110011));
        check_eq("unmapped_ascii", 32'(dig0[15:8]), 32'(8'h00));

        // Reset asserted while a pop is in progress.
        @(negedge clk);
        ready = 1'b1;
        data  = 8'h32;
        @(posedge clk);
        #1;
        check_eq("abort_pop_low", 32'(nd0), 32'(1'b0));
        clrn = 1'b0;
        model_reset();
        #1;
        check_eq("abort_nextdata_n", 32'({nd0, nd1}), 32'(2'b11));
        check_eq("abort_digit", 32'(dig0), 32'(24'h0));
        check_eq("abort_en", 32'(en0), 32'(6'b110000));
        ready = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("abort_no_retry", 32'({nd0, nd1}), 32'(2'b11));
        end
        check_outputs();

        do_reset();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: send_byte(pick_code());
                4, 5: send_byte(m_held ? m_cur : pick_code());
                6, 7: begin
                    send_byte(8'hF0);
                    send_byte(m_cur);
                end
                8: begin
                    code = pick_code();
                    send_byte(8'hF0);
                    send_byte(code);
                end
                default: begin
                    send_byte(8'hE0);
                    send_byte(pick_code());
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
